// File: rtl/line_render_sequencer.sv
// Sequences one background work line into the ping-pong line RAM every two scan lines.
// Define LINE_RENDER_SCROLL_EN to add per-frame scroll offsets on the glyph fetch coordinates.
module line_render_sequencer #(
  parameter int LINE_PIXELS = 400,
  parameter int LINES       = 300,
  parameter int PIPE_STAGES = 3,
  parameter int PRELOAD_Y   = 665
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        line_start,
  input  logic [10:0] counter_x,
  input  logic [9:0]  counter_y,
  input  logic        clr_overrun,
`ifdef LINE_RENDER_SCROLL_EN
  input  logic [8:0]  scroll_x,
  input  logic [8:0]  scroll_y,
`endif
  output logic        work_en,
  output logic [8:0]  work_x,
  output logic [8:0]  work_y,
  output logic [8:0]  fetch_x,
  output logic [8:0]  fetch_y,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic        line_done,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    WORK,
    WAIT_END,
    WAIT_LINE
  } state_t;

  localparam logic [8:0] LAST_X      = 9'(LINE_PIXELS + PIPE_STAGES - 1);
  localparam logic [8:0] LAST_Y      = 9'(LINES - 1);
  localparam logic [8:0] FILL_X      = 9'(PIPE_STAGES);
  localparam logic [9:0] PRELOAD_ROW = 10'(PRELOAD_Y);
  localparam logic [9:0] ADDR_OFFSET = 10'(PIPE_STAGES);

  state_t     state, state_next;
  logic [8:0] work_x_next, work_y_next;
  logic       line_done_next, frame_done_next, overrun_next, wr_en_next;
  logic       preload_hit;

  assign preload_hit = (counter_y == PRELOAD_ROW) && (counter_x == '0);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next      = state;
    work_x_next     = work_x;
    work_y_next     = work_y;
    line_done_next  = 1'b0;
    frame_done_next = 1'b0;
    overrun_next    = overrun;

    case (state)
      IDLE: begin
        if (enable) state_next = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (preload_hit) begin
          work_x_next = '0;
          work_y_next = '0;
          state_next  = WORK;
        end
      end
      WORK: begin
        if (work_x == LAST_X) begin
          work_x_next    = '0;
          line_done_next = 1'b1;
          state_next     = WAIT_END;
        end else begin
          work_x_next = work_x + 9'd1;
        end
      end
      WAIT_END: begin
        if (line_start) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (line_start) begin
          if (work_y < LAST_Y) begin
            work_y_next = work_y + 9'd1;
            state_next  = WORK;
          end else begin
            frame_done_next = 1'b1;
            state_next      = WAIT_FRAME;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A new violation in the same cycle as a clear must survive, so set is applied last.
    if (clr_overrun) overrun_next = 1'b0;
    if (line_start && (state == WORK)) overrun_next = 1'b1;

    // Registered strobe computed from next-state values so it lines up with work_x/work_en.
    wr_en_next = (state_next == WORK) && (work_x_next >= FILL_X);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      work_x     <= '0;
      work_y     <= '0;
      wr_en      <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      work_x     <= work_x_next;
      work_y     <= work_y_next;
      wr_en      <= wr_en_next;
      line_done  <= line_done_next;
      frame_done <= frame_done_next;
      overrun    <= overrun_next;
    end
  end

  assign work_en = (state == WORK);

  // Address is held at zero outside write cycles; during writes it removes the pipeline delay.
  assign wr_addr = wr_en ? ({work_y[0], work_x} - ADDR_OFFSET) : '0;

`ifdef LINE_RENDER_SCROLL_EN
  logic [8:0] shadow_x, shadow_y;

  // Scroll is sampled once per frame at preload so the picture never tears mid-frame.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x <= '0;
      shadow_y <= '0;
    end else if ((state == WAIT_FRAME) && (state_next == WORK)) begin
      shadow_x <= scroll_x;
      shadow_y <= scroll_y;
    end
  end

  assign fetch_x = work_x + shadow_x;
  assign fetch_y = work_y + shadow_y;
`else
  assign fetch_x = work_x;
  assign fetch_y = work_y;
`endif

endmodule
